// File: rtl/oven_timer_ctrl.sv
// Oven cook-time controller: button edge detect, seconds setpoint, 1 Hz countdown,
// heater enable and a one-cycle completion pulse.
module oven_timer_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int MAX_SEC  = 5999,
    parameter int STEP_SEC = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_stop,
    input  logic        btn_plus,
    input  logic        btn_minus,
    input  logic        door_open,
    output logic        heater,
    output logic        done,
    output logic [12:0] remaining,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

    localparam int              PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [13:0]     MAX_V      = 14'(MAX_SEC);
    localparam logic [13:0]     STEP_V     = 14'(STEP_SEC);

    state_t        st;
    logic [PW-1:0] presc;
    logic          prev_start, prev_stop, prev_plus, prev_minus;
    logic          p_start, p_stop, p_plus, p_minus;
    logic [13:0]   sum_plus, sum_tick_plus;
    logic [12:0]   rem_plus, rem_minus, rem_tick_plus;
    logic          tick, start_ok;

    assign p_start = btn_start & ~prev_start;
    assign p_stop  = btn_stop  & ~prev_stop;
    assign p_plus  = btn_plus  & ~prev_plus;
    assign p_minus = btn_minus & ~prev_minus;

    // Saturating setpoint arithmetic, evaluated in 14 bits so the sum cannot wrap.
    assign sum_plus      = {1'b0, remaining} + STEP_V;
    assign sum_tick_plus = {1'b0, remaining} + STEP_V - 14'd1;
    assign rem_plus      = (sum_plus > MAX_V) ? MAX_V[12:0] : sum_plus[12:0];
    assign rem_tick_plus = (sum_tick_plus > MAX_V) ? MAX_V[12:0] : sum_tick_plus[12:0];
    assign rem_minus     = ({1'b0, remaining} > STEP_V) ? (remaining - STEP_V[12:0]) : 13'd0;

    assign tick     = (presc == PRESC_LAST);
    assign start_ok = p_start && !door_open && (remaining != 13'd0);

    assign heater = (st == RUN);
    assign state  = st;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st         <= IDLE;
            remaining  <= '0;
            presc      <= '0;
            done       <= 1'b0;
            prev_start <= 1'b0;
            prev_stop  <= 1'b0;
            prev_plus  <= 1'b0;
            prev_minus <= 1'b0;
        end else begin
            prev_start <= btn_start;
            prev_stop  <= btn_stop;
            prev_plus  <= btn_plus;
            prev_minus <= btn_minus;
            done       <= 1'b0;
            case (st)
                IDLE: begin
                    if (p_stop)       remaining <= '0;
                    else if (start_ok) begin
                        st    <= RUN;
                        presc <= '0;
                    end
                    else if (p_plus)  remaining <= rem_plus;
                    else if (p_minus) remaining <= rem_minus;
                end
                RUN: begin
                    // Leaving RUN freezes the prescaler where it is.
                    if (p_stop || door_open) st <= PAUSE;
                    else if (tick) begin
                        presc <= '0;
                        if (p_plus) remaining <= rem_tick_plus;
                        else begin
                            remaining <= remaining - 13'd1;
                            if (remaining == 13'd1) begin
                                st   <= DONE;
                                done <= 1'b1;
                            end
                        end
                    end else begin
                        presc <= presc + PW'(1);
                        if (p_plus) remaining <= rem_plus;
                    end
                end
                PAUSE: begin
                    if (p_stop) begin
                        st        <= IDLE;
                        remaining <= '0;
                    end
                    else if (start_ok) st        <= RUN;
                    else if (p_plus)   remaining <= rem_plus;
                    else if (p_minus)  remaining <= rem_minus;
                end
                DONE: begin
                    remaining <= '0;
                    if (p_start || p_stop || p_plus || p_minus) st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/oven_timer_ctrl.md
# oven_timer_ctrl

Cook-time controller for the oven. It sits directly downstream of the per-button debouncers and consumes their stable levels for start, stop, plus, minus and the door switch. It detects press edges, keeps a seconds setpoint, counts it down at 1 Hz, drives the heater enable, and signals completion.

## Interface
- TICK_DIV, 50_000_000: clock cycles per countdown second; legal range ≥ 2.
- MAX_SEC, 5999: setpoint ceiling in seconds (99:59); legal range 1..8191.
- STEP_SEC, 10: seconds added or removed per plus/minus press; legal range 1..MAX_SEC.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- btn_start  in  1  debounced level, 1 = pressed.
- btn_stop  in  1  debounced level, 1 = pressed.
- btn_plus  in  1  debounced level, 1 = pressed.
- btn_minus  in  1  debounced level, 1 = pressed.
- door_open  in  1  debounced level, 1 = door open.
- heater  out  1  heater enable.
- done  out  1  one-cycle completion pulse.
- remaining  out  13  seconds left / setpoint, unsigned.
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

## Operation
- Edge detect:
  - One previous-level register per button; reset value 0.
  - A press is `level & ~prev`. Holding a button produces exactly one press.
  - door_open is used as a level, not an edge.
- Priority among simultaneous events, highest first: stop, door_open, start, plus, minus. Only the highest-priority applicable event acts in a cycle.
- IDLE:
  - plus: remaining = min(remaining+STEP_SEC, MAX_SEC).
  - minus: remaining = max(remaining−STEP_SEC, 0). Saturates, no wrap.
  - stop: remaining = 0.
  - start: goes to RUN only if remaining ≠ 0 and door_open = 0. Otherwise start is ignored.
  - Entry to RUN from IDLE clears the prescaler.
- RUN:
  - Prescaler counts 0..TICK_DIV−1. On the terminal count it wraps to 0 and remaining decrements.
  - Decrement from 1 to 0 moves the state to DONE on the same edge.
  - stop goes to PAUSE.
  - door_open = 1 goes to PAUSE.
  - plus adds STEP_SEC, saturating at MAX_SEC.
  - minus and start are ignored.
  - If a plus press coincides with a tick, the result is remaining − 1 + STEP_SEC, saturated to MAX_SEC.
- PAUSE:
  - Prescaler and remaining hold.
  - start with door_open = 0 returns to RUN, keeping the prescaler value.
  - stop goes to IDLE with remaining = 0.
  - plus and minus adjust remaining as in IDLE.
  - If minus reaches 0, the state stays PAUSE and a later start is ignored.
- DONE:
  - remaining = 0.
  - Any press (start, stop, plus or minus) returns to IDLE with no other effect.
- heater = 1 only while state = RUN, decoded from the state register.
- done = 1 for exactly the first cycle in DONE.
- Reset mid-operation:
  - state = IDLE, remaining = 0, prescaler = 0, heater = 0, done = 0, all prev registers = 0.
  - A button held through reset release counts as one press on the first clock after release.

## Timing
- Press to effect: level rises before edge N; state/remaining update at edge N; outputs change after edge N. One-cycle latency; no combinational input-to-output paths.
- First decrement after IDLE→RUN at edge N: edge N+TICK_DIV.
- Subsequent decrements: every TICK_DIV cycles while in RUN.
- Time spent in PAUSE does not advance the prescaler.
- heater deasserts the cycle after the edge that leaves RUN, including door open and stop.
- done asserts in the cycle after the edge on which remaining reaches 0.
- All outputs are 0 while rst = 0.

## Test plan
Benches use TICK_DIV=4, MAX_SEC=100, STEP_SEC=10.
- Reset, then 3 plus presses, then start → remaining 30 and state RUN on the start edge; first decrement 4 cycles later; heater = 1 throughout RUN.
- remaining 10, 11 plus presses → remaining 100, saturated. Then 12 minus presses → remaining 0. Then start → state stays IDLE.
- RUN with remaining 1 → after the tick, remaining 0, state DONE, done = 1 for exactly one cycle, heater = 0. Then press plus → IDLE, remaining 0.
- RUN, wait 2 cycles after a tick, raise door_open → PAUSE, heater = 0. Lower door and press start → next decrement 2 cycles after resuming.
- start and stop rising together in IDLE with remaining 20 → stop wins: state IDLE, remaining 0.
- Hold plus for 50 cycles → exactly one +10.
- Assert rst mid-RUN → all outputs 0 immediately.
